// File: rtl/obi_wb_bridge_pipe.sv
// obi_wb_bridge_pipe: OBI slave to Wishbone classic master with request queue; optional bus timeout via OBI_WB_TIMEOUT_EN
module obi_wb_bridge_pipe #(
   parameter int unsigned        ADDR_W      = 32,
   parameter int unsigned        DATA_W      = 32,
   parameter int unsigned        DEPTH       = 2,
   parameter logic [ADDR_W-1:0]  ADDR_MASK   = ADDR_W'(32'h000F_FFFF),
   parameter int unsigned        TIMEOUT_CYC = 256
) (
   input  logic                obi_clk_i,
   input  logic                soc_rst_ni,
   input  logic                obi_req_i,
   output logic                obi_gnt_o,
   input  logic [ADDR_W-1:0]   obi_addr_i,
   input  logic                obi_we_i,
   input  logic [DATA_W/8-1:0] obi_be_i,
   input  logic [DATA_W-1:0]   obi_wdata_i,
   output logic                obi_rvalid_o,
   output logic [DATA_W-1:0]   obi_rdata_o,
   output logic                obi_err_o,
   output logic [ADDR_W-1:0]   wb_adr_o,
   input  logic [DATA_W-1:0]   wb_dat_i,
   output logic [DATA_W-1:0]   wb_dat_o,
   output logic                wb_we_o,
   output logic [DATA_W/8-1:0] wb_sel_o,
   output logic                wb_stb_o,
   output logic                wb_cyc_o,
   input  logic                wb_ack_i,
   input  logic                wb_err_i
);
   localparam int unsigned BW = DATA_W / 8;
   localparam int unsigned EW = ADDR_W + 1 + BW + DATA_W;
   localparam int unsigned PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   typedef enum logic {IDLE, BUS} state_e;
   logic [EW-1:0]     mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] wb_adr_q, wb_adr_d, head_adr;
   logic [DATA_W-1:0] wb_dat_q, wb_dat_d, head_dat, rdata_q, rdata_d;
   logic [BW-1:0]     wb_sel_q, wb_sel_d, head_be;
   logic              wb_we_q, wb_we_d, head_we;
   logic              wb_cyc_q, wb_cyc_d, wb_stb_q, wb_stb_d;
   logic              rvalid_q, rvalid_d, err_q, err_d;
   logic              push, pop, done, fail, tmo;
   assign obi_gnt_o = soc_rst_ni & obi_req_i & (count_q < CW'(DEPTH));
   assign push      = obi_req_i & obi_gnt_o;
   assign pop       = (state_q == IDLE) & (count_q != '0);
   assign {head_adr, head_we, head_be, head_dat} = mem_q[rd_ptr_q];
`ifdef OBI_WB_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
   assign tmo_inc = tmo_q + 1'b1;
   assign tmo     = (state_q == BUS) & (tmo_inc == TW'(TIMEOUT_CYC));
   assign tmo_d   = pop ? '0 : (state_q == BUS) ? tmo_inc : tmo_q;
   always_ff @(posedge obi_clk_i or negedge soc_rst_ni) begin
      if (!soc_rst_ni) tmo_q <= '0;
      else tmo_q <= tmo_d;
   end
`else
   logic unused_tmo;
   assign unused_tmo = |TIMEOUT_CYC;
   assign tmo = 1'b0;
`endif
   // an ack coinciding with the timeout completes normally; a real error always wins
   assign done = (state_q == BUS) & (wb_ack_i | wb_err_i | tmo);
   assign fail = wb_err_i | (tmo & ~wb_ack_i);
   always_comb begin
      wr_ptr_d = push ? ((wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
      rd_ptr_d = pop  ? ((rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
      state_d  = pop ? BUS : done ? IDLE : state_q;
      wb_adr_d = pop ? head_adr : wb_adr_q;
      wb_dat_d = pop ? head_dat : wb_dat_q;
      wb_we_d  = pop ? head_we : done ? 1'b0 : wb_we_q;
      wb_sel_d = pop ? head_be : done ? '0 : wb_sel_q;
      wb_cyc_d = pop | (wb_cyc_q & ~done);
      wb_stb_d = pop | (wb_stb_q & ~done);
      rvalid_d = done;
      err_d    = done & fail;
      rdata_d  = (done & ~fail & ~wb_we_q) ? wb_dat_i : '0;
   end
   always_ff @(posedge obi_clk_i) begin
      if (push) mem_q[wr_ptr_q] <= {obi_addr_i & ADDR_MASK, obi_we_i, obi_be_i, obi_wdata_i};
   end
   always_ff @(posedge obi_clk_i or negedge soc_rst_ni) begin
      if (!soc_rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= IDLE;
         wb_adr_q <= '0;
         wb_dat_q <= '0;
         wb_we_q  <= 1'b0;
         wb_sel_q <= '0;
         wb_cyc_q <= 1'b0;
         wb_stb_q <= 1'b0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         state_q  <= state_d;
         wb_adr_q <= wb_adr_d;
         wb_dat_q <= wb_dat_d;
         wb_we_q  <= wb_we_d;
         wb_sel_q <= wb_sel_d;
         wb_cyc_q <= wb_cyc_d;
         wb_stb_q <= wb_stb_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end
   assign wb_adr_o     = wb_adr_q;
   assign wb_dat_o     = wb_dat_q;
   assign wb_we_o      = wb_we_q;
   assign wb_sel_o     = wb_sel_q;
   assign wb_cyc_o     = wb_cyc_q;
   assign wb_stb_o     = wb_stb_q;
   assign obi_rvalid_o = rvalid_q;
   assign obi_rdata_o  = rdata_q;
   assign obi_err_o    = err_q;
endmodule

// File: tb/tb_obi_wb_bridge_pipe.sv
// tb_obi_wb_bridge_pipe: randomized bench for obi_wb_bridge_pipe against a transaction-level model
module tb_obi_wb_bridge_pipe;
   localparam int          DEPTH = 2;
   localparam int          TMO   = 16;
   localparam logic [31:0] MASK  = 32'h000F_FFFF;
   typedef struct packed {
      logic [31:0] a;
      logic        we;
      logic [3:0]  be;
      logic [31:0] d;
   } txn_t;
   logic        obi_clk_i = 1'b0;
   logic        soc_rst_ni = 1'b0;
   logic        obi_req_i = 1'b0, obi_gnt_o, obi_we_i = 1'b0;
   logic [31:0] obi_addr_i = '0, obi_wdata_i = '0, obi_rdata_o;
   logic [3:0]  obi_be_i = '0, wb_sel_o;
   logic        obi_rvalid_o, obi_err_o, wb_we_o, wb_stb_o, wb_cyc_o;
   logic        wb_ack_i = 1'b0, wb_err_i = 1'b0;
   logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i = '0;
   obi_wb_bridge_pipe #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
      .obi_clk_i(obi_clk_i), .soc_rst_ni(soc_rst_ni),
      .obi_req_i(obi_req_i), .obi_gnt_o(obi_gnt_o), .obi_addr_i(obi_addr_i),
      .obi_we_i(obi_we_i), .obi_be_i(obi_be_i), .obi_wdata_i(obi_wdata_i),
      .obi_rvalid_o(obi_rvalid_o), .obi_rdata_o(obi_rdata_o), .obi_err_o(obi_err_o),
      .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
      .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
      .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
   );
   always #5 obi_clk_i = ~obi_clk_i;
   int n_tests = 0, n_fail = 0;
   txn_t stim[$], pend[$], m_cur;
   logic m_busy = 0, m_start = 0, m_rv = 0, m_err = 0, acc_prev = 0;
   logic [31:0] m_rdata = '0, fix_dat = '0, last_adr = '0, last_rdata = '0;
   int m_bus = 0, s_cnt = 0, s_code = 0, lat = 0, resp_q[$];
   bit gap = 0, rand_lat = 0, rand_err = 0, use_fix = 0, no_resp = 0, spur = 0;
   int n_rv = 0, n_err = 0, stalls = 0;
   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask
   task automatic tick();
      logic done, tmo, exp_gnt;
      txn_t t;
      @(negedge obi_clk_i);
      if (m_start) m_bus = 1;
      else if (m_busy) m_bus++;
      check("cyc", wb_cyc_o, m_busy);
      check("stb", wb_stb_o, m_busy);
      check("rvalid", obi_rvalid_o, m_rv);
      if (m_rv) begin
         n_rv++;
         if (obi_err_o) n_err++;
         last_rdata = obi_rdata_o;
         check("rdata", obi_rdata_o, m_rdata);
         check("err", obi_err_o, m_err);
      end
      if (m_start) begin
         last_adr = wb_adr_o;
         check("adr", wb_adr_o, m_cur.a);
         check("we", wb_we_o, m_cur.we);
         check("sel", wb_sel_o, m_cur.be);
         check("wdat", wb_dat_o, m_cur.d);
      end
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_dat_i = use_fix ? fix_dat : $urandom;
      if (spur) wb_ack_i = 1'b1;
      else if (m_busy && !no_resp) begin
         if (m_start) begin
            s_cnt = rand_lat ? int'($urandom_range(0, 3)) : lat;
            if (resp_q.size() > 0) s_code = resp_q.pop_front();
            else if (rand_err) s_code = ($urandom_range(0, 7) == 0) ? 1 : ($urandom_range(0, 15) == 0) ? 2 : 0;
            else s_code = 0;
         end
         if (s_cnt == 0) begin
            wb_ack_i = (s_code != 1);
            wb_err_i = (s_code != 0);
         end else s_cnt--;
      end
      if (acc_prev) obi_req_i = 1'b0;
      acc_prev = 1'b0;
      if (!obi_req_i && stim.size() > 0 && (!gap || $urandom_range(0, 2) != 0)) begin
         obi_req_i = 1'b1;
         obi_addr_i = stim[0].a;
         obi_we_i = stim[0].we;
         obi_be_i = stim[0].be;
         obi_wdata_i = stim[0].d;
      end else if (!obi_req_i) begin
         obi_addr_i = $urandom;
         obi_wdata_i = $urandom;
      end
      exp_gnt = obi_req_i && pend.size() < DEPTH;
      #1 check("gnt", obi_gnt_o, exp_gnt);
      if (obi_req_i && !exp_gnt) stalls++;
`ifdef OBI_WB_TIMEOUT_EN
      tmo = m_busy && m_bus == TMO;
`else
      tmo = 1'b0;
`endif
      done = m_busy && (wb_ack_i || wb_err_i || tmo);
      m_rv = done;
      if (done) begin
         m_err = wb_err_i || (tmo && !wb_ack_i);
         m_rdata = (m_err || m_cur.we) ? 32'h0 : wb_dat_i;
      end
      m_start = !m_busy && pend.size() > 0;
      if (m_start) begin
         m_cur = pend.pop_front();
         m_busy = 1'b1;
      end else if (done) m_busy = 1'b0;
      if (obi_req_i && exp_gnt) begin
         t = stim.pop_front();
         t.a = t.a & MASK;
         pend.push_back(t);
         acc_prev = 1'b1;
      end
   endtask
   task automatic drain(input int max);
      int n = 0;
      while ((stim.size() > 0 || pend.size() > 0 || m_busy || m_rv || (obi_req_i && !acc_prev)) && n < max) begin
         tick();
         n++;
      end
      check("drain_bound", n < max, 1);
   endtask
   task automatic add(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] d);
      txn_t t;
      t.a = a; t.we = we; t.be = be; t.d = d;
      stim.push_back(t);
   endtask
   initial begin
      int rv0, er0, n;
      obi_req_i = 1'b1;
      repeat (3) @(posedge obi_clk_i);
      #1;
      check("rst_gnt", obi_gnt_o, 0);
      check("rst_cyc", wb_cyc_o, 0);
      check("rst_stb", wb_stb_o, 0);
      check("rst_rvalid", obi_rvalid_o, 0);
      check("rst_rdata", obi_rdata_o, 0);
      check("rst_err", obi_err_o, 0);
      check("rst_adr", wb_adr_o, 0);
      check("rst_sel", {wb_we_o, wb_sel_o}, 0);
      check("rst_dat", wb_dat_o, 0);
      obi_req_i = 1'b0;
      @(negedge obi_clk_i);
      soc_rst_ni = 1'b1;
      // test 1: single read, ack 3 cycles after stb
      use_fix = 1; fix_dat = 32'hCAFE_F00D; lat = 3;
      add(32'h8001_2344, 1'b0, 4'hF, 32'h1234_5678);
      drain(50);
      check("t1_adr", last_adr, 32'h0001_2344);
      check("t1_rdata", last_rdata, 32'hCAFE_F00D);
      use_fix = 0;
      // test 2: four writes, slow slave
      lat = 5; stalls = 0; rv0 = n_rv;
      for (int i = 0; i < 4; i++) add($urandom, 1'b1, 4'b0011, $urandom);
      drain(200);
      check("t2_rv_cnt", n_rv - rv0, 4);
      check("t2_gnt_stall", stalls > 0, 1);
      // test 3: ack and err together, then a normal read
      lat = 1; rv0 = n_rv; er0 = n_err;
      resp_q.push_back(2);
      resp_q.push_back(0);
      add($urandom, 1'b0, 4'hF, 0);
      add($urandom, 1'b0, 4'hF, 0);
      drain(100);
      check("t3_rv_cnt", n_rv - rv0, 2);
      check("t3_err_cnt", n_err - er0, 1);
      // test 4: silent slave
      no_resp = 1; er0 = n_err;
      add($urandom, 1'b0, 4'hF, 0);
`ifdef OBI_WB_TIMEOUT_EN
      drain(60);
      check("t4_tmo_err", n_err - er0, 1);
`else
      repeat (104) tick();
      check("t4_cyc_hold", wb_cyc_o, 1);
`endif
      // test 5: reset with a transfer in flight and two queued
      n = m_busy ? 2 : 3;
      for (int i = 0; i < n; i++) add($urandom, 1'b0, 4'hF, 0);
      n = 0;
      while (!(m_busy && pend.size() == 2) && n < 30) begin
         tick();
         n++;
      end
      check("t5_setup", n < 30, 1);
      #2 soc_rst_ni = 1'b0;
      obi_req_i = 1'b1;
      #1;
      check("t5_cyc", wb_cyc_o, 0);
      check("t5_stb", wb_stb_o, 0);
      check("t5_gnt", obi_gnt_o, 0);
      check("t5_rvalid", obi_rvalid_o, 0);
      stim.delete(); pend.delete();
      m_busy = 0; m_start = 0; m_rv = 0; acc_prev = 0; no_resp = 0;
      obi_req_i = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
      @(posedge obi_clk_i);
      @(negedge obi_clk_i);
      soc_rst_ni = 1'b1;
      rv0 = n_rv;
      add($urandom, 1'b0, 4'hF, 0);
      drain(50);
      check("t5_rv_cnt", n_rv - rv0, 1);
      // test 6: spurious ack while idle
      rv0 = n_rv;
      spur = 1;
      tick();
      spur = 0;
      repeat (3) tick();
      check("t6_no_rv", n_rv - rv0, 0);
      add($urandom, 1'b1, 4'hA, $urandom);
      drain(50);
      check("t6_rv_cnt", n_rv - rv0, 1);
      // randomized traffic
      gap = 1; rand_lat = 1; rand_err = 1; rv0 = n_rv;
      for (int i = 0; i < 80; i++) add($urandom, 1'($urandom), 4'($urandom), $urandom);
      drain(3000);
      check("rand_rv_cnt", n_rv - rv0, 80);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/obi_wb_bridge_pipe.md
Name: obi_wb_bridge_pipe

Overview:
Single-clock OBI-slave to Wishbone-classic-master bridge with a parametrised request queue, so the OBI master can have several requests outstanding while the bridge keeps exactly one Wishbone transfer in flight.
- Successor to the first-generation dual-clock bridge, which supported only one transaction at a time.
- Adds configurable address masking, Wishbone error propagation to OBI, and an optional bus timeout.
- Sits between the core data/instruction OBI port and the SoC Wishbone interconnect.

Parameters:
ADDR_W, 32, address width of both interfaces
DATA_W, 32, data width (multiple of 8)
DEPTH, 2, request-queue entries (power of 2, >=1)
ADDR_MASK, 32'h000F_FFFF, AND-mask applied to the OBI address to form wb_adr_o
TIMEOUT_CYC, 256, Wishbone cycles allowed before forced termination (only with OBI_WB_TIMEOUT_EN)

Ports:
obi_clk_i  in  1  clock for all logic
soc_rst_ni  in  1  reset, asynchronous, active-low
obi_req_i  in  1  OBI request
obi_gnt_o  out  1  OBI grant
obi_addr_i  in  ADDR_W  OBI address
obi_we_i  in  1  1 = write, 0 = read
obi_be_i  in  DATA_W/8  byte enables
obi_wdata_i  in  DATA_W  write data
obi_rvalid_o  out  1  response valid, one-cycle pulse
obi_rdata_o  out  DATA_W  read data
obi_err_o  out  1  response error, qualified by rvalid
wb_adr_o  out  ADDR_W  Wishbone address
wb_dat_i  in  DATA_W  Wishbone read data
wb_dat_o  out  DATA_W  Wishbone write data
wb_we_o  out  1  Wishbone write enable
wb_sel_o  out  DATA_W/8  Wishbone byte select
wb_stb_o  out  1  Wishbone strobe
wb_cyc_o  out  1  Wishbone cycle
wb_ack_i  in  1  Wishbone acknowledge
wb_err_i  in  1  Wishbone error

Behaviour:
- Clock and reset: all state is on obi_clk_i; reset is soc_rst_ni, asynchronous, active-low.
- Reset values: every registered output is 0; queue empty; FSM in IDLE; obi_gnt_o forced to 0 while reset is asserted.
- Grant: obi_gnt_o = obi_req_i & (count < DEPTH), combinational.
  - count is the registered queue occupancy; a pop in the same cycle does not free a slot.
  - Accept occurs when req & gnt; the queue captures {addr & ADDR_MASK, we, be, wdata}.
- Wishbone FSM states: IDLE, BUS.
  - IDLE, queue non-empty: pop the head; on the same edge load wb_adr_o/wb_we_o/wb_sel_o/wb_dat_o and set wb_cyc_o = wb_stb_o = 1; go to BUS.
  - BUS, wb_ack_i | wb_err_i sampled high: clear cyc, stb, we, sel; set obi_rvalid_o = 1 for one cycle; go to IDLE.
    - obi_rdata_o = wb_dat_i for a read with ack; 0 for writes or on error.
    - obi_err_o = wb_err_i.
  - ack and err both high: error wins (err = 1, rdata = 0).
- Latency: accept at edge 0 with the queue empty and FSM in IDLE gives cyc/stb high after edge 1. A slave ack sampled at edge k gives rvalid high in the cycle after edge k.
- Back-to-back: at least one idle cycle (cyc low) between consecutive Wishbone transfers.
- Ordering: responses are strictly in request order. At most DEPTH+1 requests are outstanding (queue plus in flight).
- No backpressure on responses, per OBI without rready; the master must always accept rvalid.
- ack/err seen while in IDLE: ignored, no rvalid generated.
- Queue pointers wrap modulo DEPTH; a simultaneous push and pop leaves count unchanged.
- Reset asserted mid-transfer:
  - cyc, stb, rvalid and gnt drop asynchronously.
  - The queue is flushed and the in-flight transfer is abandoned.
  - No response is generated for lost requests; the OBI master shares soc_rst_ni.

Optional Feature:
Macro OBI_WB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYC+1) clears on entry to BUS and increments each cycle in BUS.
  - When it reaches TIMEOUT_CYC with no ack/err, the bridge terminates the transfer exactly like an error: cyc/stb drop, rvalid pulses with err = 1 and rdata = 0.
  - An ack arriving in the same cycle as the timeout takes precedence.
- Not defined: no counter is built; BUS waits indefinitely; TIMEOUT_CYC is unused.

Test Plan:
1. Read addr 0x8001_2344, be = 4'hF; slave acks 3 cycles after stb with 0xCAFE_F00D -> wb_adr_o = 0x0001_2344, we = 0; one rvalid pulse with rdata 0xCAFE_F00D, err = 0.
2. DEPTH = 2; four consecutive writes with be = 4'b0011; slave ack latency 5 -> gnt low while 2 queued + 1 in flight; four Wishbone cycles in order with sel = 4'b0011; four rvalids, rdata = 0.
3. Read with wb_err_i and wb_ack_i high together -> rvalid with err = 1, rdata = 0x0; next queued read completes normally.
4. TIMEOUT_CYC = 16, no slave response -> with the macro: cyc drops after 16 BUS cycles, rvalid with err = 1. Without the macro: cyc still high after 100 cycles.
5. Reset pulse while cyc is high and 2 requests are queued -> cyc/stb/gnt/rvalid 0 immediately; after release a new read completes with no stale rvalid.
6. Spurious wb_ack_i for 1 cycle while in IDLE with the queue empty -> no rvalid, no state change.
